// File: rtl/alu_pkg.sv
// alu_pkg: constants shared by the ALU, its issue unit and benches.
//   DATA_W / SEL_W / LAST_OP : default operand width, select width, highest legal opcode
//   OP_*                     : opcode encodings decoded by alu
//   alu_state_t, IDLE, EXEC  : issue-unit FSM state encoding
package alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SEL_W   = 5;
    localparam int unsigned LAST_OP = 14;

    localparam logic [SEL_W-1:0] OP_ADD   = 5'd1;
    localparam logic [SEL_W-1:0] OP_SUB   = 5'd2;
    localparam logic [SEL_W-1:0] OP_MUL   = 5'd3;
    localparam logic [SEL_W-1:0] OP_AND   = 5'd4;
    localparam logic [SEL_W-1:0] OP_OR    = 5'd5;
    localparam logic [SEL_W-1:0] OP_XOR   = 5'd6;
    localparam logic [SEL_W-1:0] OP_NOR   = 5'd7;
    localparam logic [SEL_W-1:0] OP_SLL   = 5'd8;
    localparam logic [SEL_W-1:0] OP_SRL   = 5'd9;
    localparam logic [SEL_W-1:0] OP_SRA   = 5'd10;
    localparam logic [SEL_W-1:0] OP_SLT   = 5'd11;
    localparam logic [SEL_W-1:0] OP_SLTU  = 5'd12;
    localparam logic [SEL_W-1:0] OP_NOT   = 5'd13;
    localparam logic [SEL_W-1:0] OP_PASSB = 5'd14;

    typedef logic [0:0] alu_state_t;
    localparam alu_state_t IDLE = 1'b0;
    localparam alu_state_t EXEC = 1'b1;

endpackage

// File: rtl/alu.sv
// alu: combinational ALU producing a 2*DATA_W result.
//   a_i, b_i  : operands
//   sel_i     : opcode (alu_pkg::OP_*); unknown opcodes give 0
//   result_o  : 2*DATA_W result; ADD/SUB/MUL use the full width, logic ops fill the low word
module alu
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0]   a_i,
    input  logic [DATA_W-1:0]   b_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic [2*DATA_W-1:0] result_o
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    logic [2*DATA_W-1:0] a_ext;
    logic [2*DATA_W-1:0] b_ext;
    logic [SH_W-1:0]     sh;

    assign a_ext = {{DATA_W{1'b0}}, a_i};
    assign b_ext = {{DATA_W{1'b0}}, b_i};
    assign sh    = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        case (sel_i)
            OP_ADD:   result_o = a_ext + b_ext;
            OP_SUB:   result_o = a_ext - b_ext;
            OP_MUL:   result_o = a_ext * b_ext;
            OP_AND:   result_o = {{DATA_W{1'b0}}, a_i & b_i};
            OP_OR:    result_o = {{DATA_W{1'b0}}, a_i | b_i};
            OP_XOR:   result_o = {{DATA_W{1'b0}}, a_i ^ b_i};
            OP_NOR:   result_o = {{DATA_W{1'b0}}, ~(a_i | b_i)};
            OP_SLL:   result_o = {{DATA_W{1'b0}}, a_i << sh};
            OP_SRL:   result_o = {{DATA_W{1'b0}}, a_i >> sh};
            OP_SRA:   result_o = {{DATA_W{1'b0}}, $signed(a_i) >>> sh};
            OP_SLT:   result_o = {{(2*DATA_W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU:  result_o = {{(2*DATA_W-1){1'b0}}, a_i < b_i};
            OP_NOT:   result_o = {{DATA_W{1'b0}}, ~a_i};
            OP_PASSB: result_o = b_ext;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_resp_fifo.sv
// alu_resp_fifo: first-word-fall-through FIFO for ALU responses.
//   clk, rst_n    : clock, async active-low reset (empties the FIFO)
//   push_i        : write push_data_i; caller guarantees space
//   pop_i         : consume the head entry (ignored while empty)
//   valid_o       : head entry present
//   full_o        : DEPTH entries held
//   data_o        : head entry, 0 while empty
module alu_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic             full_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_en;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign pop_en  = pop_i && valid_o;
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_i, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: data_o is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // A push into a full FIFO (without a same-cycle pop) would drop data.
    no_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(push_i && full_o && !pop_en));

endmodule

// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequential front-end for the combinational alu.
//   clk, rst_n                   : clock, async active-low reset
//   req_valid/req_ready          : request handshake; req_a, req_b, req_sel, req_tag
//   alu_a, alu_b, alu_sel        : registered operands/select driven into alu
//   alu_out                      : alu result, sampled only on the capture edge
//   resp_valid/resp_ready        : response handshake from an FWFT FIFO
//   resp_hi, resp_lo             : upper/lower words of the captured result
//   resp_tag, resp_err           : returned tag, illegal-select flag
//   busy                         : operation in flight
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W     = alu_pkg::DATA_W,
    parameter int unsigned SEL_W      = alu_pkg::SEL_W,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned LAST_OP    = alu_pkg::LAST_OP,
    parameter int unsigned SETTLE_CYC = 1,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    input  logic [SEL_W-1:0]    req_sel,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [SEL_W-1:0]    alu_sel,
    input  logic [2*DATA_W-1:0] alu_out,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [DATA_W-1:0]   resp_hi,
    output logic [DATA_W-1:0]   resp_lo,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                resp_err,
    output logic                busy
);

    localparam int unsigned RES_W  = 2 * DATA_W;
    localparam int unsigned FIFO_W = RES_W + TAG_W + 1;
    localparam int unsigned CNT_W  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    alu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              err_q, err_d;

    logic              fifo_full;
    logic              sel_bad;
    logic              accept;
    logic              push;
    logic              pop;
    logic [FIFO_W-1:0] push_data;
    logic [FIFO_W-1:0] head_data;

    assign sel_bad   = (req_sel == '0) || (req_sel > SEL_W'(LAST_OP));
    // Space is reserved at accept time, so the capture push can never overflow.
    assign req_ready = (state_q == IDLE) && !fifo_full;
    assign accept    = req_valid && req_ready;
    assign push      = (state_q == EXEC) && (cnt_q == '0);
    assign pop       = resp_valid && resp_ready;
    assign busy      = (state_q == EXEC);
    assign push_data = {err_q, tag_q, (err_q ? {RES_W{1'b0}} : alu_out)};

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign {resp_err, resp_tag, resp_hi, resp_lo} = head_data;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        tag_d     = tag_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = EXEC;
                    cnt_d     = CNT_W'(SETTLE_CYC - 1);
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_sel_d = sel_bad ? '0 : req_sel;
                    tag_d     = req_tag;
                    err_d     = sel_bad;
                end
            end
            EXEC: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            tag_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            tag_q     <= tag_d;
            err_q     <= err_d;
        end
    end

    alu_resp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (resp_valid),
        .full_o      (fifo_full),
        .data_o      (head_data)
    );

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit driving the real alu.
// u_dut uses SETTLE_CYC=1, u_dut3 uses SETTLE_CYC=3; both share clk/rst_n.
module tb_alu_issue_unit;

    localparam logic [4:0] OP_ADD = alu_pkg::OP_ADD;
    localparam logic [4:0] OP_SUB = alu_pkg::OP_SUB;
    localparam logic [4:0] OP_MUL = alu_pkg::OP_MUL;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err, busy;
    logic [31:0] req_a, req_b, alu_a, alu_b, resp_hi, resp_lo;
    logic [4:0]  req_sel, alu_sel;
    logic [3:0]  req_tag, resp_tag;
    logic [63:0] alu_out;

    logic        req_valid_3, req_ready_3, resp_valid_3, resp_ready_3, resp_err_3, busy_3;
    logic [31:0] req_a_3, req_b_3, alu_a_3, alu_b_3, resp_hi_3, resp_lo_3;
    logic [4:0]  req_sel_3, alu_sel_3;
    logic [3:0]  req_tag_3, resp_tag_3;
    logic [63:0] alu_out_3;

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;
    int unsigned cyc      = 0;

    logic [3:0]  q_tag[$];
    logic [31:0] q_hi[$];
    logic [31:0] q_lo[$];
    logic        q_err[$];

    alu_issue_unit #(
        .SETTLE_CYC (1),
        .RESP_DEPTH (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sel    (req_sel),
        .req_tag    (req_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_hi    (resp_hi),
        .resp_lo    (resp_lo),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    alu u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .sel_i    (alu_sel),
        .result_o (alu_out)
    );

    alu_issue_unit #(
        .SETTLE_CYC (3),
        .RESP_DEPTH (2)
    ) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid_3),
        .req_ready  (req_ready_3),
        .req_a      (req_a_3),
        .req_b      (req_b_3),
        .req_sel    (req_sel_3),
        .req_tag    (req_tag_3),
        .alu_a      (alu_a_3),
        .alu_b      (alu_b_3),
        .alu_sel    (alu_sel_3),
        .alu_out    (alu_out_3),
        .resp_valid (resp_valid_3),
        .resp_ready (resp_ready_3),
        .resp_hi    (resp_hi_3),
        .resp_lo    (resp_lo_3),
        .resp_tag   (resp_tag_3),
        .resp_err   (resp_err_3),
        .busy       (busy_3)
    );

    alu u_alu3 (
        .a_i      (alu_a_3),
        .b_i      (alu_b_3),
        .sel_i    (alu_sel_3),
        .result_o (alu_out_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every response handshake on the main DUT, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            q_tag.push_back(resp_tag);
            q_hi.push_back(resp_hi);
            q_lo.push_back(resp_lo);
            q_err.push_back(resp_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_tag.delete();
        q_hi.delete();
        q_lo.delete();
        q_err.delete();
    endtask

    // Present a request on u_dut and hold it until accepted (bounded).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] sel,
                         input logic [3:0] tag, output int unsigned acc_cyc);
        bit done;
        done      = 1'b0;
        req_a     = a;
        req_b     = b;
        req_sel   = sel;
        req_tag   = tag;
        req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                step();
                done = 1'b1;
                break;
            end
            step();
        end
        req_valid = 1'b0;
        acc_cyc   = cyc;
        chk_cnt++;
        if (!done) $display("FAIL issue_timeout tag=%0d got no accept exp accept", tag);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_a        = '0;
        req_b        = '0;
        req_sel      = '0;
        req_tag      = '0;
        resp_ready   = 1'b0;
        req_valid_3  = 1'b0;
        req_a_3      = '0;
        req_b_3      = '0;
        req_sel_3    = '0;
        req_tag_3    = '0;
        resp_ready_3 = 1'b1;
        step();
        step();
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy);
        else pass_cnt++;
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready);
        else pass_cnt++;
        chk_cnt++;
        if ({alu_a, alu_b, alu_sel} !== 69'd0)
            $display("FAIL reset_alu_regs got %h/%h/%h exp 0", alu_a, alu_b, alu_sel);
        else pass_cnt++;
        chk_cnt++;
        if ({resp_valid, resp_hi, resp_lo, resp_tag, resp_err} !== 70'd0)
            $display("FAIL reset_resp got v=%b %h_%h t=%h e=%b exp all 0",
                     resp_valid, resp_hi, resp_lo, resp_tag, resp_err);
        else pass_cnt++;
    endtask

    task automatic test_basic_add();
        resp_ready = 1'b1;
        req_a      = 32'h0A;
        req_b      = 32'h02;
        req_sel    = OP_ADD;
        req_tag    = 4'd3;
        req_valid  = 1'b1;
        chk_cnt++;
        if (req_ready !== 1'b1) $display("FAIL basic_ready_pre got %b exp 1", req_ready);
        else pass_cnt++;
        step();
        req_valid = 1'b0;
        chk_cnt++;
        if (alu_a !== 32'h0A || alu_sel !== OP_ADD)
            $display("FAIL basic_alu_regs got a=%h sel=%0d exp a=0a sel=1", alu_a, alu_sel);
        else pass_cnt++;
        chk_cnt++;
        if (busy !== 1'b1 || req_ready !== 1'b0 || resp_valid !== 1'b0)
            $display("FAIL basic_exec got busy=%b rdy=%b rv=%b exp 1/0/0",
                     busy, req_ready, resp_valid);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (resp_valid !== 1'b1 || resp_lo !== 32'h0000000C || resp_hi !== 32'h0)
            $display("FAIL basic_resp got v=%b %h_%h exp 1 00000000_0000000c",
                     resp_valid, resp_hi, resp_lo);
        else pass_cnt++;
        chk_cnt++;
        if (resp_tag !== 4'd3 || resp_err !== 1'b0 || busy !== 1'b0)
            $display("FAIL basic_tag got tag=%0d err=%b busy=%b exp 3/0/0",
                     resp_tag, resp_err, busy);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (resp_valid !== 1'b0 || alu_a !== 32'h0A || alu_sel !== OP_ADD)
            $display("FAIL basic_hold got rv=%b a=%h sel=%0d exp 0/0a/1",
                     resp_valid, alu_a, alu_sel);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        logic [31:0] exp_lo [1:14];
        int unsigned prev_cyc;
        int unsigned cur_cyc;
        exp_lo[1]  = 32'h00000100;  // ADD
        exp_lo[2]  = 32'h000000EC;  // SUB
        exp_lo[3]  = 32'h0000099C;  // MUL
        exp_lo[4]  = 32'h00000002;  // AND
        exp_lo[5]  = 32'h000000FE;  // OR
        exp_lo[6]  = 32'h000000FC;  // XOR
        exp_lo[7]  = 32'hFFFFFF01;  // NOR
        exp_lo[8]  = 32'h0003D800;  // SLL by 10
        exp_lo[9]  = 32'h00000000;  // SRL by 10
        exp_lo[10] = 32'h00000000;  // SRA by 10
        exp_lo[11] = 32'h00000000;  // SLT 246<10
        exp_lo[12] = 32'h00000000;  // SLTU
        exp_lo[13] = 32'hFFFFFF09;  // NOT a
        exp_lo[14] = 32'h0000000A;  // PASSB
        resp_ready = 1'b1;
        prev_cyc   = 0;
        clear_q();
        for (int s = 1; s <= 14; s++) begin
            issue(32'hF6, 32'h0A, 5'(s), 4'(s), cur_cyc);
            if (s > 1) begin
                chk_cnt++;
                if (cur_cyc - prev_cyc != 2)
                    $display("FAIL sweep_rate sel=%0d got %0d cycles exp 2", s,
                             cur_cyc - prev_cyc);
                else pass_cnt++;
            end
            prev_cyc = cur_cyc;
        end
        repeat (3) step();
        chk_cnt++;
        if (q_tag.size() != 14) $display("FAIL sweep_count got %0d exp 14", q_tag.size());
        else pass_cnt++;
        for (int s = 1; s <= 14 && s <= q_tag.size(); s++) begin
            chk_cnt++;
            if (q_tag[s-1] !== 4'(s) || q_hi[s-1] !== 32'h0 || q_lo[s-1] !== exp_lo[s] ||
                q_err[s-1] !== 1'b0)
                $display("FAIL sweep_resp sel=%0d got t=%0d %h_%h e=%b exp t=%0d 0_%h e=0",
                         s, q_tag[s-1], q_hi[s-1], q_lo[s-1], q_err[s-1], s, exp_lo[s]);
            else pass_cnt++;
        end
    endtask

    task automatic test_wide();
        int unsigned c;
        resp_ready = 1'b1;
        clear_q();
        issue(32'hFFFFFFFF, 32'h2, OP_MUL, 4'd7, c);
        issue(32'h2, 32'h5, OP_SUB, 4'd8, c);
        repeat (3) step();
        chk_cnt++;
        if (q_tag.size() != 2) $display("FAIL wide_count got %0d exp 2", q_tag.size());
        else pass_cnt++;
        if (q_tag.size() == 2) begin
            chk_cnt++;
            if (q_hi[0] !== 32'h1 || q_lo[0] !== 32'hFFFFFFFE || q_tag[0] !== 4'd7)
                $display("FAIL wide_mul got %h_%h t=%0d exp 00000001_fffffffe t=7",
                         q_hi[0], q_lo[0], q_tag[0]);
            else pass_cnt++;
            chk_cnt++;
            if (q_hi[1] !== 32'hFFFFFFFF || q_lo[1] !== 32'hFFFFFFFD || q_tag[1] !== 4'd8)
                $display("FAIL wide_sub got %h_%h t=%0d exp ffffffff_fffffffd t=8",
                         q_hi[1], q_lo[1], q_tag[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_illegal();
        logic [4:0] bad_sel [2];
        bad_sel[0] = 5'd0;
        bad_sel[1] = 5'd15;
        resp_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_a     = 32'h0A;
            req_b     = 32'h02;
            req_sel   = bad_sel[i];
            req_tag   = 4'(10 + i);
            req_valid = 1'b1;
            step();
            req_valid = 1'b0;
            chk_cnt++;
            if (alu_sel !== 5'd0 || busy !== 1'b1)
                $display("FAIL illegal_sel sel=%0d got alu_sel=%0d busy=%b exp 0/1",
                         bad_sel[i], alu_sel, busy);
            else pass_cnt++;
            step();
            chk_cnt++;
            if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_hi !== 32'h0 ||
                resp_lo !== 32'h0 || resp_tag !== 4'(10 + i))
                $display("FAIL illegal_resp sel=%0d got v=%b e=%b %h_%h t=%0d exp 1/1/0/%0d",
                         bad_sel[i], resp_valid, resp_err, resp_hi, resp_lo, resp_tag,
                         10 + i);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_backpressure();
        int unsigned c;
        bit          ready_seen;
        resp_ready = 1'b0;
        clear_q();
        issue(32'h1, 32'h1, OP_ADD, 4'd1, c);
        issue(32'h2, 32'h2, OP_ADD, 4'd2, c);
        req_a      = 32'h33;
        req_b      = 32'h1;
        req_sel    = OP_ADD;
        req_tag    = 4'd3;
        req_valid  = 1'b1;
        ready_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (req_ready) ready_seen = 1'b1;
            step();
        end
        chk_cnt++;
        if (ready_seen || req_ready !== 1'b0)
            $display("FAIL bp_ready_low got seen=%b now=%b exp 0/0", ready_seen, req_ready);
        else pass_cnt++;
        chk_cnt++;
        if (resp_valid !== 1'b1 || resp_tag !== 4'd1 || resp_lo !== 32'h2 || busy !== 1'b0)
            $display("FAIL bp_head got v=%b t=%0d lo=%h busy=%b exp 1/1/2/0",
                     resp_valid, resp_tag, resp_lo, busy);
        else pass_cnt++;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk_cnt++;
        if (req_ready !== 1'b1 || resp_tag !== 4'd2 || resp_lo !== 32'h4)
            $display("FAIL bp_after_pop got rdy=%b t=%0d lo=%h exp 1/2/4",
                     req_ready, resp_tag, resp_lo);
        else pass_cnt++;
        step();
        req_valid = 1'b0;
        chk_cnt++;
        if (busy !== 1'b1 || alu_a !== 32'h33)
            $display("FAIL bp_accept3 got busy=%b a=%h exp 1/33", busy, alu_a);
        else pass_cnt++;
        step();
        resp_ready = 1'b1;
        repeat (4) step();
        chk_cnt++;
        if (q_tag.size() != 3) $display("FAIL bp_count got %0d exp 3", q_tag.size());
        else pass_cnt++;
        if (q_tag.size() == 3) begin
            chk_cnt++;
            if (q_tag[0] !== 4'd1 || q_tag[1] !== 4'd2 || q_tag[2] !== 4'd3 ||
                q_lo[2] !== 32'h34)
                $display("FAIL bp_order got %0d,%0d,%0d lo3=%h exp 1,2,3 lo3=34",
                         q_tag[0], q_tag[1], q_tag[2], q_lo[2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_exec();
        int unsigned c;
        bit          resp_seen;
        resp_ready = 1'b0;
        issue(32'h5, 32'h5, OP_ADD, 4'd5, c);
        issue(32'h6, 32'h6, OP_ADD, 4'd6, c);
        chk_cnt++;
        if (busy !== 1'b1 || resp_valid !== 1'b1)
            $display("FAIL rst_pre got busy=%b rv=%b exp 1/1", busy, resp_valid);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if (busy !== 1'b0 || {alu_a, alu_b, alu_sel} !== 69'd0)
            $display("FAIL rst_async_regs got busy=%b %h/%h/%h exp 0",
                     busy, alu_a, alu_b, alu_sel);
        else pass_cnt++;
        chk_cnt++;
        if ({resp_valid, resp_hi, resp_lo, resp_tag, resp_err} !== 70'd0 || req_ready !== 1'b1)
            $display("FAIL rst_async_resp got v=%b %h_%h t=%0d e=%b rdy=%b exp 0s rdy=1",
                     resp_valid, resp_hi, resp_lo, resp_tag, resp_err, req_ready);
        else pass_cnt++;
        step();
        step();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        clear_q();
        resp_seen  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid !== 1'b0) resp_seen = 1'b1;
        end
        chk_cnt++;
        if (resp_seen || q_tag.size() != 0)
            $display("FAIL rst_no_resp got seen=%b n=%0d exp 0/0", resp_seen, q_tag.size());
        else pass_cnt++;
    endtask

    task automatic test_settle3();
        int          busy_cycles;
        int          valid_at;
        logic [31:0] lo_at;
        logic [3:0]  tag_at;
        busy_cycles  = 0;
        valid_at     = -1;
        lo_at        = '0;
        tag_at       = '0;
        resp_ready_3 = 1'b1;
        req_a_3      = 32'h10;
        req_b_3      = 32'h20;
        req_sel_3    = OP_ADD;
        req_tag_3    = 4'd9;
        req_valid_3  = 1'b1;
        chk_cnt++;
        if (req_ready_3 !== 1'b1) $display("FAIL s3_ready got %b exp 1", req_ready_3);
        else pass_cnt++;
        step();
        req_valid_3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (busy_3) busy_cycles++;
            if (resp_valid_3 && valid_at < 0) begin
                valid_at = i;
                lo_at    = resp_lo_3;
                tag_at   = resp_tag_3;
            end
            step();
        end
        chk_cnt++;
        if (busy_cycles != 3) $display("FAIL s3_busy got %0d exp 3", busy_cycles);
        else pass_cnt++;
        chk_cnt++;
        if (valid_at != 3) $display("FAIL s3_latency got %0d exp 3", valid_at);
        else pass_cnt++;
        chk_cnt++;
        if (lo_at !== 32'h30 || tag_at !== 4'd9)
            $display("FAIL s3_resp got lo=%h t=%0d exp 30/9", lo_at, tag_at);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_add();
        test_sweep();
        test_wide();
        test_illegal();
        test_backpressure();
        test_reset_mid_exec();
        test_settle3();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequential front-end that owns the combinational `alu`. It accepts operation requests over a valid/ready handshake and drives the registered operands and select into the ALU. After a fixed settle time it captures the 64-bit `ALU_Out` and returns it, split into hi/lo words, through a small response FIFO with its own valid/ready handshake. It sits between the instruction issue logic and the ALU, so the datapath no longer drives `alu` inputs directly.

## Interface
- `DATA_W`, 32: operand width; the ALU result is 2*DATA_W.
- `SEL_W`, 5: ALU select width.
- `TAG_W`, 4: request tag width; the tag is returned unchanged.
- `LAST_OP`, 14: highest legal select value; the legal range is 1..LAST_OP.
- `SETTLE_CYC`, 1: cycles the ALU inputs are held before capture (≥1).
- `RESP_DEPTH`, 2: response FIFO depth (≥1).
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_a`, `req_b`  in  DATA_W  operands.
- `req_sel`  in  SEL_W  operation select.
- `req_tag`  in  TAG_W  request tag.
- `alu_a`, `alu_b`  out  DATA_W  registered operands to `alu`.
- `alu_sel`  out  SEL_W  registered select to `alu`.
- `alu_out`  in  2*DATA_W  ALU result.
- `resp_valid`  out  1  response available.
- `resp_ready`  in  1  consumer takes the response.
- `resp_hi`, `resp_lo`  out  DATA_W  alu_out[63:32] and alu_out[31:0].
- `resp_tag`  out  TAG_W  tag of the response.
- `resp_err`  out  1  illegal select.
- `busy`  out  1  operation in flight (state EXEC).

## Operation
- FSM states: IDLE and EXEC.
- `req_ready` = (state==IDLE) && (fifo_count < RESP_DEPTH). It is combinational, with no dependence on `req_valid`.
- IDLE → EXEC on `req_valid && req_ready`. On that edge:
  - `alu_a`/`alu_b` load the request operands.
  - `alu_sel` loads `req_sel` if the select is legal, else 0.
  - The unit latches the tag and the illegal flag, and loads the settle counter with SETTLE_CYC-1.
- EXEC: the counter decrements each cycle. On the edge where the counter is 0, the unit pushes {err, tag, alu_out} into the FIFO and returns to IDLE.
- Illegal select (0 or >LAST_OP):
  - Takes the same path and the same latency.
  - The pushed result is 0 and err=1.
- `alu_*` hold their last value between operations and do not clear on completion.
- Response FIFO:
  - First-word-fall-through.
  - Pop on `resp_valid && resp_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - A push never sees a full FIFO, because space is reserved at accept time. The FIFO must still assert-guard against overflow in simulation.
- While empty, `resp_hi`/`resp_lo`/`resp_tag`/`resp_err` read 0.
- Only one operation is in flight at a time; requests are never reordered.

## Timing
- Reset values (async, on `rst_n`=0):
  - State IDLE; FIFO empty; counter 0.
  - `alu_a`, `alu_b`, `alu_sel` = 0.
  - `resp_valid` = 0; `resp_*` data = 0.
  - `busy` = 0.
  - `req_ready` = 1 once `rst_n` is high, because it is combinational from IDLE and an empty FIFO.
- Reset mid-EXEC drops the in-flight operation and any queued responses; nothing is pushed afterwards.
- Latency:
  - Accept at edge k, push at edge k+SETTLE_CYC.
  - `resp_valid` is high in the cycle following edge k+SETTLE_CYC when the FIFO was empty.
- Throughput: one request per SETTLE_CYC+1 cycles. `req_ready` is low during EXEC.
- Backpressure: with `resp_ready`=0, `req_ready` falls after RESP_DEPTH responses are queued. It rises in the cycle after the first pop.
- `alu_out` is sampled only on the capture edge; glitches at other times are ignored.

## Structure
- Shared package `alu_pkg`:
  - DATA_W, SEL_W, LAST_OP.
  - Opcode constants shared with `alu`, including OP_ADD=5'd1.
  - The FSM state enum (IDLE, EXEC).
- One sub-module: `alu_resp_fifo`, a parameterised FWFT FIFO.
  - Width 2*DATA_W+TAG_W+1.
  - Count width $clog2(RESP_DEPTH+1).
  - Pointers wrap modulo RESP_DEPTH.
- The FSM, settle counter and operand registers stay in `alu_issue_unit`.
- The bench instantiates `alu_issue_unit` together with the real `alu`.

## Test plan
- Reset, then A=0x0A, B=0x02, sel=OP_ADD, tag=3, with `resp_ready`=1:
  - `alu_a`=0x0A after the accept edge.
  - `resp_valid` one cycle later, with `resp_lo`=0x0000000C, `resp_hi`=0, tag=3, err=0.
- Sweep sel 1..14 with A=0xF6, B=0x0A: every response matches the `alu` reference model; tags are returned in order; one accept every 2 cycles.
- sel=0 and sel=15: `alu_sel`=0, response after the same latency with err=1, hi/lo=0.
- Hold `resp_ready`=0 and issue 3 requests:
  - Two responses are queued and `req_ready` stays 0.
  - Pulse `resp_ready` once: the first response pops and the 3rd request is accepted on the following cycle.
- Assert `rst_n` low in the EXEC cycle: all outputs reach their reset values immediately, and no response appears after release.
- SETTLE_CYC=3 build: push occurs 3 edges after accept and `busy` is high for exactly 3 cycles.
